// File: rtl/shot_sequencer.sv
// Basketball shot controller: latches aim on a shoot press, steps ball
// physics once per video frame, detects basket/miss, holds the result for a
// fixed number of frames and re-arms. All outputs come straight from flops.
module shot_sequencer #(
  parameter int START_X       = 80,
  parameter int START_Y       = 400,
  parameter int GRAVITY       = 1,
  parameter int VMAX          = 15,
  parameter int HOOP_X_MIN    = 520,
  parameter int HOOP_X_MAX    = 560,
  parameter int HOOP_Y        = 160,
  parameter int FLOOR_Y       = 460,
  parameter int SCREEN_W      = 640,
  parameter int RESULT_FRAMES = 60
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       frame_tick,
  input  logic       btn_shoot,
  input  logic       score_clr,
  input  logic [4:0] aim_vx,
  input  logic [4:0] aim_vy,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_visible,
  output logic [1:0] state,
  output logic [6:0] score,
  output logic [6:0] shots,
  output logic       hit,
  output logic       miss
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLIGHT = 2'd1,
    S_SCORED = 2'd2,
    S_MISSED = 2'd3
  } state_t;

  localparam int CW = $clog2(RESULT_FRAMES + 1);

  localparam logic signed [10:0] SX    = 11'(START_X);
  localparam logic signed [10:0] SY    = 11'(START_Y);
  localparam logic signed [10:0] HXMIN = 11'(HOOP_X_MIN);
  localparam logic signed [10:0] HXMAX = 11'(HOOP_X_MAX);
  localparam logic signed [10:0] HY    = 11'(HOOP_Y);
  localparam logic signed [10:0] FY    = 11'(FLOOR_Y);
  localparam logic signed [10:0] SW    = 11'(SCREEN_W);
  localparam logic signed [5:0]  GRAV  = 6'(GRAVITY);
  localparam logic signed [5:0]  VMX   = 6'(VMAX);
  localparam logic [CW-1:0]      CNT_LAST = CW'(RESULT_FRAMES - 1);
  localparam logic [6:0]         SAT   = 7'd99;

  state_t             state_q, state_d;
  logic signed [10:0] x_q, x_d, y_q, y_d;
  logic        [5:0]  vx_q, vx_d;
  logic signed [5:0]  vy_q, vy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [6:0]         score_q, score_d, shots_q, shots_d;
  logic               hit_q, hit_d, miss_q, miss_d;
  logic               btn_q;
  logic [9:0]         bx_q, bx_d, by_q, by_d;
  logic               vis_q, vis_d;

  // One physics step worth of candidate values, used only in FLIGHT.
  logic signed [10:0] x_nx, y_nx;
  logic signed [5:0]  vy_inc, vy_nx;
  logic               shoot, basket, off_field;

  assign shoot     = btn_shoot & ~btn_q;
  assign x_nx      = x_q + $signed({5'b0, vx_q});
  assign y_nx      = y_q + $signed({{5{vy_q[5]}}, vy_q});
  assign vy_inc    = vy_q + GRAV;
  assign vy_nx     = (vy_inc > VMX) ? VMX : vy_inc;
  // Basket only when falling through the rim line inside the opening.
  assign basket    = (vy_q > 6'sd0) && (y_q < HY) && (y_nx >= HY) &&
                     (x_nx >= HXMIN) && (x_nx <= HXMAX);
  assign off_field = (y_nx >= FY) || (x_nx >= SW);

  // Next-state and next-output logic for the shot FSM.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    shots_d = shots_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (score_clr) begin
          score_d = '0;
          shots_d = '0;
        end else if (shoot && (aim_vx != 5'd0)) begin
          state_d = S_FLIGHT;
          vx_d    = {1'b0, aim_vx};
          vy_d    = 6'd0 - {1'b0, aim_vy};
          shots_d = (shots_q == SAT) ? shots_q : shots_q + 7'd1;
        end
      end
      S_FLIGHT: begin
        if (frame_tick) begin
          x_d   = x_nx;
          y_d   = y_nx;
          vy_d  = vy_nx;
          cnt_d = '0;
          if (basket) begin
            state_d = S_SCORED;
            score_d = (score_q == SAT) ? score_q : score_q + 7'd1;
            hit_d   = 1'b1;
          end else if (off_field) begin
            state_d = S_MISSED;
            miss_d  = 1'b1;
          end
        end
      end
      default: begin
        if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            x_d     = SX;
            y_d     = SY;
            vx_d    = '0;
            vy_d    = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
    endcase
    bx_d  = x_d[9:0];
    by_d  = y_d[10] ? 10'd0 : y_d[9:0];
    vis_d = (state_d == S_IDLE) || (state_d == S_FLIGHT);
  end

  // State and output registers; reset aborts any shot in progress.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= S_IDLE;
      x_q     <= SX;
      y_q     <= SY;
      vx_q    <= '0;
      vy_q    <= '0;
      cnt_q   <= '0;
      score_q <= '0;
      shots_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      btn_q   <= 1'b0;
      bx_q    <= SX[9:0];
      by_q    <= SY[9:0];
      vis_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      shots_q <= shots_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      btn_q   <= btn_shoot;
      bx_q    <= bx_d;
      by_q    <= by_d;
      vis_q   <= vis_d;
    end
  end

  assign ball_x       = bx_q;
  assign ball_y       = by_q;
  assign ball_visible = vis_q;
  assign state        = state_q;
  assign score        = score_q;
  assign shots        = shots_q;
  assign hit          = hit_q;
  assign miss         = miss_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Bench for shot_sequencer: table of known trajectories, hand-written corner
// sequences and randomized shots against a closed-form trajectory model.
module tb_shot_sequencer;

  localparam int SX = 80, SY = 400, G = 1, VMAX = 15;
  localparam int HXMIN = 520, HXMAX = 560, HY = 160, FY = 460, SW = 640, RF = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ft = 1'b0, btn = 1'b0, clr = 1'b0;
  logic [4:0] avx = '0, avy = '0;
  logic [9:0] ball_x, ball_y, o3_x, o3_y;
  logic       vis, hit, miss, o3_vis, o3_hit, o3_miss;
  logic [1:0] state, o3_state;
  logic [6:0] score, shots, o3_score, o3_shots;

  always #5 clk = ~clk;

  shot_sequencer dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .frame_tick(ft), .btn_shoot(btn),
    .score_clr(clr), .aim_vx(avx), .aim_vy(avy), .ball_x(ball_x), .ball_y(ball_y),
    .ball_visible(vis), .state(state), .score(score), .shots(shots),
    .hit(hit), .miss(miss));

  // Small-court instance for the short scoring trajectory.
  shot_sequencer #(.START_Y(100), .HOOP_Y(100), .HOOP_X_MIN(90), .HOOP_X_MAX(130)) dut3 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .frame_tick(ft), .btn_shoot(btn),
    .score_clr(clr), .aim_vx(avx), .aim_vy(avy), .ball_x(o3_x), .ball_y(o3_y),
    .ball_visible(o3_vis), .state(o3_state), .score(o3_score), .shots(o3_shots),
    .hit(o3_hit), .miss(o3_miss));

  typedef struct { int vx; int vy; int ev; int n; int x; int y; } vec_t;
  vec_t tbl[4];
  int   ys3[5];
  int   checks = 0, errors = 0;
  int   m_score = 0, m_shots = 0;
  int   ev, nev, ex, ey;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: closed-form trajectory after n frames.
  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction
  function automatic int traj_x(input int vx, input int n);
    return SX + vx * n;
  endfunction
  function automatic int traj_y(input int vy0, input int n);
    int s = SY;
    for (int k = 0; k < n; k++) s += min2(k * G - vy0, VMAX);
    return s;
  endfunction
  function automatic int vy_before(input int vy0, input int n);
    return min2((n - 1) * G - vy0, VMAX);
  endfunction
  function automatic int clampy(input int y);
    return (y < 0) ? 0 : y;
  endfunction
  function automatic int sat_inc(input int v);
    return (v >= 99) ? 99 : v + 1;
  endfunction

  task automatic do_tick();
    @(negedge clk); ft = 1'b1;
    @(negedge clk); ft = 1'b0;
  endtask
  task automatic pulse_btn();
    @(negedge clk); btn = 1'b1;
    @(negedge clk); btn = 1'b0;
  endtask
  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic run_shot(input int vx, input int vy, input bit noise, input bit hold_btn,
                          output int o_ev, output int o_n, output int o_x, output int o_y);
    int x, y, py;
    bit sc, ms;
    @(negedge clk); avx = 5'(vx); avy = 5'(vy); btn = 1'b1;
    @(negedge clk); if (!hold_btn) btn = 1'b0;
    m_shots = sat_inc(m_shots);
    chk("launch_state", int'(state), 1);
    chk("launch_shots", int'(shots), m_shots);
    o_ev = 0; o_n = 0; o_x = SX; o_y = SY;
    for (int n = 1; n <= 200 && o_ev == 0; n++) begin
      if (noise && (n == 3 || $urandom_range(7, 0) == 0)) begin
        pulse_btn();
        pulse_clr();
      end
      do_tick();
      x  = traj_x(vx, n);
      y  = traj_y(vy, n);
      py = traj_y(vy, n - 1);
      sc = (vy_before(vy, n) > 0) && (py < HY) && (y >= HY) && (x >= HXMIN) && (x <= HXMAX);
      ms = !sc && ((y >= FY) || (x >= SW));
      if (sc) m_score = sat_inc(m_score);
      chk("flight_x", int'(ball_x), x);
      chk("flight_y", int'(ball_y), clampy(y));
      chk("flight_state", int'(state), sc ? 2 : (ms ? 3 : 1));
      chk("flight_hit", int'(hit), int'(sc));
      chk("flight_miss", int'(miss), int'(ms));
      chk("flight_vis", int'(vis), int'(!(sc || ms)));
      chk("flight_score", int'(score), m_score);
      chk("flight_shots", int'(shots), m_shots);
      if (sc || ms) begin
        o_ev = sc ? 1 : 2; o_n = n; o_x = x; o_y = y;
      end
    end
    if (o_ev == 0) chk("flight_timeout", 0, 1);
  endtask

  task automatic hold_result(input int r_ev, input int r_x, input int r_y, input bit noise);
    for (int i = 1; i <= RF; i++) begin
      if (noise && i == 10) begin
        pulse_btn();
        pulse_clr();
      end
      do_tick();
      if (i < RF) begin
        chk("hold_state", int'(state), (r_ev == 1) ? 2 : 3);
        if (i == 1 || i == RF - 1) begin
          chk("hold_x", int'(ball_x), r_x);
          chk("hold_y", int'(ball_y), clampy(r_y));
          chk("hold_vis", int'(vis), 0);
          chk("hold_hit", int'(hit), 0);
          chk("hold_miss", int'(miss), 0);
        end
      end else begin
        chk("rearm_state", int'(state), 0);
        chk("rearm_x", int'(ball_x), SX);
        chk("rearm_y", int'(ball_y), SY);
        chk("rearm_vis", int'(vis), 1);
        chk("rearm_score", int'(score), m_score);
        chk("rearm_shots", int'(shots), m_shots);
      end
    end
  endtask

  task automatic try_zero_vx();
    @(negedge clk); avx = 5'd0; avy = 5'($urandom_range(31, 0)); btn = 1'b1;
    @(negedge clk); btn = 1'b0;
    @(negedge clk);
    chk("zero_vx_state", int'(state), 0);
    chk("zero_vx_shots", int'(shots), m_shots);
  endtask

  task automatic sync_reset();
    @(negedge clk); ft = 1'b0; btn = 1'b0; clr = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_score = 0; m_shots = 0;
  endtask

  initial begin
    #990_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{vx: 10, vy: 0,  ev: 2, n: 12, x: 200, y: 466};
    tbl[1] = '{vx: 16, vy: 22, ev: 1, n: 28, x: 528, y: 162};
    tbl[2] = '{vx: 31, vy: 0,  ev: 2, n: 12, x: 452, y: 466};
    tbl[3] = '{vx: 31, vy: 10, ev: 2, n: 19, x: 669, y: 381};
    ys3 = '{98, 97, 97, 98, 100};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_x", int'(ball_x), SX);
    chk("rst_y", int'(ball_y), SY);
    chk("rst_vis", int'(vis), 1);
    chk("rst_score", int'(score), 0);
    chk("rst_shots", int'(shots), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_miss", int'(miss), 0);
    @(negedge clk); rst_n = 1'b1;

    // Table of known trajectories
    for (int i = 0; i < 4; i++) begin
      run_shot(tbl[i].vx, tbl[i].vy, 1'b0, 1'b0, ev, nev, ex, ey);
      chk("tbl_event", ev, tbl[i].ev);
      chk("tbl_tick", nev, tbl[i].n);
      chk("tbl_x", int'(ball_x), tbl[i].x);
      chk("tbl_y", int'(ball_y), tbl[i].y);
      hold_result(ev, ex, ey, 1'b0);
    end

    // Ignored inputs: zero vx, edges in FLIGHT/SCORED, held button
    try_zero_vx();
    run_shot(16, 22, 1'b1, 1'b0, ev, nev, ex, ey);
    hold_result(ev, ex, ey, 1'b1);
    run_shot(10, 0, 1'b0, 1'b1, ev, nev, ex, ey);
    hold_result(ev, ex, ey, 1'b0);
    repeat (4) @(negedge clk);
    chk("held_btn_state", int'(state), 0);
    chk("held_btn_shots", int'(shots), m_shots);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    chk("release_state", int'(state), 0);

    // Randomized shots against the model
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(3, 0) == 0) try_zero_vx();
      repeat ($urandom_range(3, 0)) @(negedge clk);
      run_shot($urandom_range(31, 1), $urandom_range(31, 0), 1'b1, 1'b0, ev, nev, ex, ey);
      hold_result(ev, ex, ey, 1'b1);
    end

    // Short scoring trajectory on the small court
    sync_reset();
    @(negedge clk); avx = 5'd10; avy = 5'd2; btn = 1'b1;
    @(negedge clk); btn = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      do_tick();
      chk("court3_y", int'(o3_y), ys3[k-1]);
      chk("court3_x", int'(o3_x), 80 + 10 * k);
      if (k < 5) chk("court3_flight", int'(o3_state), 1);
    end
    chk("court3_state", int'(o3_state), 2);
    chk("court3_hit", int'(o3_hit), 1);
    chk("court3_miss", int'(o3_miss), 0);
    chk("court3_vis", int'(o3_vis), 0);
    chk("court3_score", int'(o3_score), 1);
    chk("court3_shots", int'(o3_shots), 1);
    sync_reset();

    // Saturation of score and shot counts
    for (int s = 0; s < 100; s++) begin
      run_shot(16, 22, 1'b0, 1'b0, ev, nev, ex, ey);
      hold_result(ev, ex, ey, 1'b0);
    end
    chk("sat_score", int'(score), 99);
    chk("sat_shots", int'(shots), 99);

    // Clear wins over a same-cycle shoot edge
    @(negedge clk); avx = 5'd5; avy = 5'd3; btn = 1'b1; clr = 1'b1;
    @(negedge clk); btn = 1'b0; clr = 1'b0;
    m_score = 0; m_shots = 0;
    @(negedge clk);
    chk("clr_score", int'(score), 0);
    chk("clr_shots", int'(shots), 0);
    chk("clr_state", int'(state), 0);

    // Reset mid-flight aborts without pulses
    run_shot(10, 0, 1'b0, 1'b0, ev, nev, ex, ey);
    hold_result(ev, ex, ey, 1'b0);
    @(negedge clk); avx = 5'd10; avy = 5'd0; btn = 1'b1;
    @(negedge clk); btn = 1'b0;
    repeat (3) do_tick();
    chk("pre_abort_state", int'(state), 1);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("abort_state", int'(state), 0);
    chk("abort_x", int'(ball_x), SX);
    chk("abort_y", int'(ball_y), SY);
    chk("abort_score", int'(score), 0);
    chk("abort_shots", int'(shots), 0);
    chk("abort_vis", int'(vis), 1);
    repeat (2) do_tick();
    chk("abort_hit", int'(hit), 0);
    chk("abort_miss", int'(miss), 0);
    @(negedge clk); rst_n = 1'b1;
    m_score = 0; m_shots = 0;
    repeat (3) do_tick();
    chk("post_abort_state", int'(state), 0);
    chk("post_abort_x", int'(ball_x), SX);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
